// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter (5..DATA_W data bits, parity modes, 1/2 stop bits)
// Ports: clk/rst_n clock and async active-low reset; tx_data/tx_valid/tx_ready frame handshake;
//   cfg_dbits/cfg_par/cfg_stop2/baud_div frame format (bit = baud_div+1 clocks), latched on accept;
//   txd serial line (idle high); tx_busy frame in progress; frame_done end-of-frame pulse.
// Option: define UART_TX_BREAK_EN to add brk_req, which holds txd low while asserted in idle.
module uart_tx_cfg #(
  parameter int DATA_W = 8,
  parameter int DIV_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [3:0]        cfg_dbits,
  input  logic [2:0]        cfg_par,
  input  logic              cfg_stop2,
  input  logic [DIV_W-1:0]  baud_div,
`ifdef UART_TX_BREAK_EN
  input  logic              brk_req,
`endif
  output logic              txd,
  output logic              tx_busy,
  output logic              frame_done
);
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
`ifdef UART_TX_BREAK_EN
    , BREAK, BRK_END
`endif
  } state_t;
  localparam logic [3:0] DW = 4'(DATA_W);
  state_t state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n, div, div_n;
  logic [DATA_W-1:0] shift, shift_n, mask;
  logic [3:0] nb, nb_n, bc, bc_n, n_in;
  logic pen, pen_n, pb, pb_n, s2, s2_n, pb_in, txd_n, tick;
  always_comb begin
    n_in = cfg_dbits < 4'd5 ? 4'd5 : (cfg_dbits > DW ? DW : cfg_dbits);
    mask = '0;
    for (int i = 0; i < DATA_W; i++) mask[i] = 4'(i) < n_in;
    // parity is computed once at accept over the bits that will actually be sent
    pb_in = cfg_par == 3'd1 ? ~^(tx_data & mask) : cfg_par == 3'd2 ? ^(tx_data & mask) : cfg_par == 3'd3;
    tick = cnt == '0;
    state_n = state;
    cnt_n = tick ? div : cnt - 1'b1;
    div_n = div;
    shift_n = shift;
    nb_n = nb;
    bc_n = bc;
    pen_n = pen;
    pb_n = pb;
    s2_n = s2;
    case (state)
      IDLE: begin
        cnt_n = cnt;
`ifdef UART_TX_BREAK_EN
        if (brk_req) state_n = BREAK; else
`endif
        if (tx_valid && tx_ready) begin
          state_n = START;
          cnt_n = baud_div;
          div_n = baud_div;
          shift_n = tx_data;
          nb_n = n_in;
          bc_n = '0;
          pen_n = cfg_par inside {[3'd1:3'd4]};
          pb_n = pb_in;
          s2_n = cfg_stop2;
        end
      end
      START: if (tick) state_n = DATA;
      DATA: if (tick) begin
        shift_n = shift >> 1;
        bc_n = bc + 4'd1;
        if (bc == nb - 4'd1) begin
          state_n = pen ? PARITY : STOP;
          bc_n = '0;
        end
      end
      PARITY: if (tick) state_n = STOP;
      STOP: if (tick) begin
        bc_n = bc + 4'd1;
        if (!s2 || bc == 4'd1) state_n = IDLE;
      end
`ifdef UART_TX_BREAK_EN
      // keep the counter primed so the trailing high period is a full bit
      BREAK: begin
        cnt_n = div;
        if (!brk_req) state_n = BRK_END;
      end
      BRK_END: if (tick) state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
    txd_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? pb_n : 1'b1;
`ifdef UART_TX_BREAK_EN
    if (state_n == BREAK) txd_n = 1'b0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      div <= '0;
      shift <= '0;
      nb <= '0;
      bc <= '0;
      pen <= 1'b0;
      pb <= 1'b0;
      s2 <= 1'b0;
      txd <= 1'b1;
      tx_ready <= 1'b0;
      tx_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      div <= div_n;
      shift <= shift_n;
      nb <= nb_n;
      bc <= bc_n;
      pen <= pen_n;
      pb <= pb_n;
      s2 <= s2_n;
      txd <= txd_n;
      tx_ready <= state_n == IDLE;
      tx_busy <= state_n != IDLE;
      frame_done <= state == STOP && state_n == IDLE;
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: table-driven bench for uart_tx_cfg with hand-computed serial bit sequences
module tb_uart_tx_cfg;
  typedef struct {
    logic [7:0]  data;
    logic [3:0]  dbits;
    logic [2:0]  par;
    logic        stop2;
    logic [15:0] div;
    int          n;
    logic [12:0] bits;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n, tx_valid, tx_ready, cfg_stop2, txd, tx_busy, frame_done, brk_req;
  logic [7:0] tx_data;
  logic [3:0] cfg_dbits;
  logic [2:0] cfg_par;
  logic [15:0] baud_div, last_div;
  vec_t v[8];
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  uart_tx_cfg dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .cfg_dbits(cfg_dbits),
    .cfg_par(cfg_par),
    .cfg_stop2(cfg_stop2),
    .baud_div(baud_div),
`ifdef UART_TX_BREAK_EN
    .brk_req(brk_req),
`endif
    .txd(txd),
    .tx_busy(tx_busy),
    .frame_done(frame_done)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  task automatic launch(input int i);
    int t = 0;
    while (tx_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("v%0d ready before accept", i), {31'd0, tx_ready}, 32'd1);
    tx_data = v[i].data;
    cfg_dbits = v[i].dbits;
    cfg_par = v[i].par;
    cfg_stop2 = v[i].stop2;
    baud_div = v[i].div;
    last_div = v[i].div;
    tx_valid = 1'b1;
    @(negedge clk);
  endtask
  // entered in the first cycle after accept; checks every clock of every bit
  task automatic frame(input int i, input bit hold, input bit perturb);
    logic [2:0] got, want;
    if (!hold) tx_valid = 1'b0;
    if (perturb) begin
      cfg_dbits = 4'd5;
      baud_div = '0;
      tx_data = 8'h00;
      cfg_par = 3'd1;
      tx_valid = 1'b1;
    end
    for (int b = 0; b < v[i].n; b++) begin
      want = {2'b01, v[i].bits[v[i].n-1-b]};
      got = want;
      for (int c = 0; c <= int'(v[i].div); c++) begin
        if ({frame_done, tx_busy, txd} !== want) got = {frame_done, tx_busy, txd};
        @(negedge clk);
        if (perturb) tx_valid = 1'b0;
      end
      chk($sformatf("v%0d bit%0d {done,busy,txd}", i, b), {29'd0, got}, {29'd0, want});
    end
    chk($sformatf("v%0d end {done,busy,ready,txd}", i), {28'd0, frame_done, tx_busy, tx_ready, txd}, 32'hB);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [2:0] got;
    v[0] = '{8'hA5, 4'd8,  3'd0, 1'b0, 16'd3, 10, 13'b0101001011};
    v[1] = '{8'h41, 4'd7,  3'd1, 1'b0, 16'd1, 10, 13'b0100000111};
    v[2] = '{8'hFF, 4'd8,  3'd2, 1'b1, 16'd0, 12, 13'b011111111011};
    v[3] = '{8'hF3, 4'd3,  3'd3, 1'b0, 16'd2, 8,  13'b01100111};
    v[4] = '{8'h3C, 4'd15, 3'd4, 1'b1, 16'd1, 12, 13'b000111100011};
    v[5] = '{8'h2D, 4'd6,  3'd6, 1'b0, 16'd0, 8,  13'b01011011};
    v[6] = '{8'hE7, 4'd5,  3'd2, 1'b0, 16'd1, 8,  13'b01110011};
    v[7] = '{8'h00, 4'd8,  3'd1, 1'b0, 16'd0, 11, 13'b00000000011};
    rst_n = 1'b0;
    tx_valid = 1'b0;
    brk_req = 1'b0;
    tx_data = '0;
    cfg_dbits = 4'd8;
    cfg_par = '0;
    cfg_stop2 = 1'b0;
    baud_div = '0;
    last_div = '0;
    repeat (3) @(negedge clk);
    chk("reset txd", {31'd0, txd}, 32'd1);
    chk("reset ready", {31'd0, tx_ready}, 32'd0);
    chk("reset busy", {31'd0, tx_busy}, 32'd0);
    chk("reset done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset {done,busy,ready,txd}", {28'd0, frame_done, tx_busy, tx_ready, txd}, 32'h3);
    for (int i = 0; i < 8; i++) begin
      launch(i);
      frame(i, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d idle after", i), {28'd0, frame_done, tx_busy, tx_ready, txd}, 32'h3);
    end
    launch(0);
    frame(0, 1'b0, 1'b1);
    got = 3'b001;
    repeat (4) begin
      @(negedge clk);
      if ({frame_done, tx_busy, txd} !== 3'b001) got = {frame_done, tx_busy, txd};
    end
    chk("busy pulse ignored", {29'd0, got}, 32'h1);
    launch(1);
    frame(1, 1'b1, 1'b0);
    @(negedge clk);
    frame(1, 1'b0, 1'b0);
    @(negedge clk);
    chk("held valid idle after", {28'd0, frame_done, tx_busy, tx_ready, txd}, 32'h3);
`ifdef UART_TX_BREAK_EN
    baud_div = 16'd7;
    brk_req = 1'b1;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    got = 3'b010;
    for (int c = 1; c <= 20; c++) begin
      if ({tx_ready, tx_busy, txd} !== 3'b010) got = {tx_ready, tx_busy, txd};
      if (c == 20) brk_req = 1'b0;
      @(negedge clk);
    end
    chk("break low {ready,busy,txd}", {29'd0, got}, 32'h2);
    got = 3'b011;
    for (int c = 0; c <= int'(last_div); c++) begin
      if ({tx_ready, tx_busy, txd} !== 3'b011) got = {tx_ready, tx_busy, txd};
      @(negedge clk);
    end
    chk("break tail {ready,busy,txd}", {29'd0, got}, 32'h3);
    chk("break end {done,busy,ready,txd}", {28'd0, frame_done, tx_busy, tx_ready, txd}, 32'h3);
`endif
    launch(7);
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-abort txd", {31'd0, txd}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort {done,busy,ready,txd}", {28'd0, frame_done, tx_busy, tx_ready, txd}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort release {done,busy,ready,txd}", {28'd0, frame_done, tx_busy, tx_ready, txd}, 32'h3);
    got = 3'b001;
    repeat (12) begin
      @(negedge clk);
      if ({frame_done, tx_busy, txd} !== 3'b001) got = {frame_done, tx_busy, txd};
    end
    chk("abort stays idle", {29'd0, got}, 32'h1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
